// File: rtl/setn_pulse_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : setn_pulse_sequencer_if
// Description : Request/status bundle between a controller and the SETN
//               pulse sequencer.
//                 set_req  controller -> sequencer, level preset request
//                 set_ack  sequencer -> controller, one-cycle completion pulse
//                 setn     sequencer -> flop bank, active-low preset
//                 clken    sequencer -> CLKN gate, clock enable
//                 busy     sequencer -> controller, sequence in progress
// Revision    : 1.0 - initial release
// ============================================================================
interface setn_pulse_sequencer_if;
  logic set_req;
  logic set_ack;
  logic setn;
  logic clken;
  logic busy;

  modport master (
    output set_req,
    input  set_ack,
    input  setn,
    input  clken,
    input  busy
  );

  modport slave (
    input  set_req,
    output set_ack,
    output setn,
    output clken,
    output busy
  );
endinterface
`default_nettype wire

// File: rtl/setn_pulse_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : setn_pulse_sequencer
// Description : Generates a glitch-free active-low preset (setn) for a bank of
//               negative-edge set-flops, with the downstream CLKN gate held
//               off (clken=0) while the preset is asserted and for a recovery
//               window afterwards.
// Ports       : clk  - single clock, all state on rising edge
//               rn   - asynchronous active-low reset, release synchronised
//               bus  - slave side of setn_pulse_sequencer_if
//                      (set_req in; set_ack, setn, clken, busy out)
// Parameters  : SET_W - cycles setn is held low (1..15)
//               REC_W - cycles of setn high / clken low before release (0..15)
// Revision    : 1.0 - initial release
// ============================================================================
module setn_pulse_sequencer #(
  parameter int SET_W = 4,
  parameter int REC_W = 2
) (
  input  wire logic                  clk,
  input  wire logic                  rn,
  setn_pulse_sequencer_if.slave      bus
);

  localparam int C_SET_M1 = (SET_W > 0) ? SET_W - 1 : 0;
  localparam int C_REC_M1 = (REC_W > 0) ? REC_W - 1 : 0;
  localparam logic [3:0] c_set_load = C_SET_M1[3:0];
  localparam logic [3:0] c_rec_load = C_REC_M1[3:0];

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RECOVER = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  logic [1:0] r_sync;
  logic       w_run;
  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_pend;
  logic       r_reqf;
  logic       r_setn;
  logic       r_clken;
  logic       r_ack;
  logic       r_busy;

  // Reset release synchroniser: the FSM stays frozen in its reset (ASSERT)
  // state until a 1 has walked through both flops.
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], 1'b1};
    end
  end

  assign w_run = r_sync[1];

  // Outputs are registered alongside the state so setn/clken come straight
  // from flops. Reset lands in ASSERT so the flop bank is preset immediately
  // and a full (unacknowledged) sequence runs after release.
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      r_state <= ST_ASSERT;
      r_cnt   <= c_set_load;
      r_pend  <= 1'b0;
      r_reqf  <= 1'b0;
      r_setn  <= 1'b0;
      r_clken <= 1'b0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b1;
    end else if (w_run) begin
      r_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A stored pending request starts a sequence just like a live one.
          if (bus.set_req || r_pend) begin
            r_state <= ST_ASSERT;
            r_cnt   <= c_set_load;
            r_pend  <= 1'b0;
            r_reqf  <= 1'b1;
            r_setn  <= 1'b0;
            r_clken <= 1'b0;
            r_busy  <= 1'b1;
          end
        end

        ST_ASSERT: begin
          if (bus.set_req) begin
            r_pend <= 1'b1;
          end
          if (r_cnt == 4'd0) begin
            if (REC_W == 0) begin
              // No recovery window: setn and clken rise together.
              r_state <= ST_DONE;
              r_setn  <= 1'b1;
              r_clken <= 1'b1;
              r_ack   <= r_reqf;
            end else begin
              r_state <= ST_RECOVER;
              r_cnt   <= c_rec_load;
              r_setn  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        ST_RECOVER: begin
          if (bus.set_req) begin
            r_pend <= 1'b1;
          end
          if (r_cnt == 4'd0) begin
            r_state <= ST_DONE;
            r_clken <= 1'b1;
            r_ack   <= r_reqf;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        ST_DONE: begin
          if (bus.set_req) begin
            r_pend <= 1'b1;
          end
          r_state <= ST_IDLE;
          r_reqf  <= 1'b0;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
          r_setn  <= 1'b1;
          r_clken <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.set_ack = r_ack;
  assign bus.setn    = r_setn;
  assign bus.clken   = r_clken;
  assign bus.busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_setn_pulse_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_setn_pulse_sequencer
// Description : Self-checking bench. Two sequencer instances (defaults, and
//               SET_W=1/REC_W=0) are compared every cycle against a model that
//               tracks each sequence as a position counter from its first
//               preset cycle, plus literal expectations for key scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_setn_pulse_sequencer;

  logic clk = 1'b0;
  logic rn  = 1'b0;
  always #5 clk = ~clk;

  setn_pulse_sequencer_if if_a ();
  setn_pulse_sequencer_if if_b ();

  setn_pulse_sequencer #(.SET_W(4), .REC_W(2)) dut_a (
    .clk (clk),
    .rn  (rn),
    .bus (if_a)
  );

  setn_pulse_sequencer #(.SET_W(1), .REC_W(0)) dut_b (
    .clk (clk),
    .rn  (rn),
    .bus (if_b)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A sequence is "in_seq" with pos = cycles since its first preset cycle:
  // pos < sw -> preset, pos < sw+rw -> recovery, pos == sw+rw -> done.
  int sw[2] = '{4, 1};
  int rw[2] = '{2, 0};
  bit m_seq[2]  = '{1'b1, 1'b1};
  int m_pos[2]  = '{0, 0};
  bit m_pend[2] = '{1'b0, 1'b0};
  bit m_reqf[2] = '{1'b0, 1'b0};
  int m_sync[2] = '{0, 0};

  function automatic void m_reset(int k);
    m_seq[k]  = 1'b1;
    m_pos[k]  = 0;
    m_pend[k] = 1'b0;
    m_reqf[k] = 1'b0;
    m_sync[k] = 0;
  endfunction

  function automatic void m_step(int k, logic req);
    if (m_sync[k] < 2) begin
      m_sync[k]++;
      return;
    end
    if (!m_seq[k]) begin
      if (req || m_pend[k]) begin
        m_seq[k]  = 1'b1;
        m_pos[k]  = 0;
        m_reqf[k] = 1'b1;
        m_pend[k] = 1'b0;
      end
    end else begin
      if (req) m_pend[k] = 1'b1;
      if (m_pos[k] == sw[k] + rw[k]) m_seq[k] = 1'b0;
      else m_pos[k]++;
    end
  endfunction

  // returns {setn, clken, ack, busy}
  function automatic logic [3:0] m_exp(int k);
    if (!m_seq[k]) return 4'b1100;
    if (m_pos[k] < sw[k]) return 4'b0001;
    if (m_pos[k] < sw[k] + rw[k]) return 4'b1001;
    return {2'b11, m_reqf[k], 1'b1};
  endfunction

  always @(negedge rn) begin
    for (int k = 0; k < 2; k++) m_reset(k);
  end

  always @(posedge clk) begin
    if (rn) begin
      m_step(0, if_a.set_req);
      m_step(1, if_b.set_req);
    end
  end

  // ---------------- compare process ----------------
  int ack_cnt[2]   = '{0, 0};
  int lowrun[2]    = '{0, 0};
  bit prev_ack[2]  = '{1'b0, 1'b0};
  bit prev_setn[2] = '{1'b1, 1'b1};

  always @(negedge clk) begin
    logic [3:0] act [2];
    logic [3:0] exp;
    act[0] = {if_a.setn, if_a.clken, if_a.set_ack, if_a.busy};
    act[1] = {if_b.setn, if_b.clken, if_b.set_ack, if_b.busy};
    for (int k = 0; k < 2; k++) begin
      exp = m_exp(k);
      chk(k == 0 ? "a.setn"  : "b.setn",  act[k][3], exp[3]);
      chk(k == 0 ? "a.clken" : "b.clken", act[k][2], exp[2]);
      chk(k == 0 ? "a.ack"   : "b.ack",   act[k][1], exp[1]);
      chk(k == 0 ? "a.busy"  : "b.busy",  act[k][0], exp[0]);
      // invariants: no clken while preset, minimum preset width, 1-cycle ack
      if (act[k][3] == 1'b0) begin
        chk(k == 0 ? "a.clken_in_preset" : "b.clken_in_preset", act[k][2], 1'b0);
        lowrun[k]++;
      end else begin
        if (prev_setn[k] == 1'b0) begin
          n_chk++;
          if (lowrun[k] < sw[k]) begin
            n_fail++;
            $display("FAIL setn_width[%0d] at %0t: got %0d, expected >= %0d",
                     k, $time, lowrun[k], sw[k]);
          end
        end
        lowrun[k] = 0;
      end
      if (act[k][1] === 1'b1) begin
        ack_cnt[k]++;
        chk(k == 0 ? "a.ack_width" : "b.ack_width", prev_ack[k], 1'b0);
      end
      prev_ack[k]  = (act[k][1] === 1'b1);
      prev_setn[k] = (act[k][3] !== 1'b0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    int a0;
    int b0;
    logic [7:0] v_setn;
    logic [7:0] v_clken;
    logic [7:0] v_ack;
    logic [7:0] v_busy;
    if_a.set_req = 1'b0;
    if_b.set_req = 1'b0;

    // Reset held: preset asserted, clock gated, busy.
    tick(3);
    chk("rst.setn",  if_a.setn,    1'b0);
    chk("rst.clken", if_a.clken,   1'b0);
    chk("rst.busy",  if_a.busy,    1'b1);
    chk("rst.ack",   if_a.set_ack, 1'b0);

    // Release: 2 sync + 4 preset + 2 recover + done, then idle, no ack.
    rn = 1'b1;
    tick(9);
    chk("post_rst.busy", if_a.busy,  1'b0);
    chk("post_rst.setn", if_a.setn,  1'b1);
    chk("post_rst.acks", ack_cnt[0], 0);
    chk("post_rst.b_busy", if_b.busy, 1'b0);

    // Single request pulse from idle: cycle-by-cycle literal pattern.
    tick(2);
    v_setn  = 8'b1111_0000;
    v_clken = 8'b1100_0000;
    v_ack   = 8'b0100_0000;
    v_busy  = 8'b0111_1111;
    if_a.set_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("pulse.setn",  if_a.setn,    v_setn[i]);
      chk("pulse.clken", if_a.clken,   v_clken[i]);
      chk("pulse.ack",   if_a.set_ack, v_ack[i]);
      chk("pulse.busy",  if_a.busy,    v_busy[i]);
      #1;
      if (i == 0) if_a.set_req = 1'b0;
    end

    // Request during preset gets queued and gets its own ack.
    tick(2);
    a0 = ack_cnt[0];
    if_a.set_req = 1'b1;
    tick(1);
    if_a.set_req = 1'b0;
    tick(2);
    if_a.set_req = 1'b1;
    tick(1);
    if_a.set_req = 1'b0;
    tick(22);
    chk("pend.acks", ack_cnt[0] - a0, 2);
    chk("pend.busy", if_a.busy, 1'b0);

    // Request held high: back-to-back sequences, period 3 on the short one.
    a0 = ack_cnt[0];
    b0 = ack_cnt[1];
    if_a.set_req = 1'b1;
    if_b.set_req = 1'b1;
    tick(12);
    chk("held.b_acks", ack_cnt[1] - b0, 4);
    chk("held.a_acks", ack_cnt[0] - a0, 1);
    if_a.set_req = 1'b0;
    if_b.set_req = 1'b0;
    tick(24);

    // Reset pulsed during recovery with a request pending.
    if_a.set_req = 1'b1;
    tick(1);
    if_a.set_req = 1'b0;
    tick(1);
    if_a.set_req = 1'b1;
    tick(1);
    if_a.set_req = 1'b0;
    tick(2);
    chk("rec.setn",  if_a.setn,  1'b1);
    chk("rec.clken", if_a.clken, 1'b0);
    a0 = ack_cnt[0];
    rn = 1'b0;
    #1;
    chk("async.setn",  if_a.setn,    1'b0);
    chk("async.clken", if_a.clken,   1'b0);
    chk("async.busy",  if_a.busy,    1'b1);
    chk("async.ack",   if_a.set_ack, 1'b0);
    #1;
    rn = 1'b1;
    @(negedge clk);
    #1;
    tick(24);
    chk("abort.acks", ack_cnt[0] - a0, 0);
    chk("abort.busy", if_a.busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/setn_pulse_sequencer.md
SETN_PULSE_SEQUENCER -- requirements
Module: setn_pulse_sequencer

Interface
REQ-001 Parameter SET_W, default 4, number of CLK cycles SETN is held low per sequence (legal 1..15).
REQ-002 Parameter REC_W, default 2, number of CLK cycles SETN is high with CLKEN low before the clock is released (legal 0..15).
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RN  input  1  reset; asynchronous assert, active-low; synchronous deassert handled internally per REQ-021.
REQ-005 SET_REQ  input  1  level request to preset the downstream negative-edge set-flop bank.
REQ-006 SET_ACK  output  1  one-cycle completion pulse for a requested sequence.
REQ-007 SETN  output  1  active-low preset to downstream flops; driven directly from a flop, glitch-free.
REQ-008 CLKEN  output  1  enable for the downstream CLKN gate; low while preset is asserted or recovering.
REQ-009 BUSY  output  1  high whenever state is not IDLE.

Function
REQ-010 The block SHALL implement FSM states IDLE, ASSERT, RECOVER, DONE with a 4-bit down-counter CNT.
REQ-011 IDLE: SETN=1, CLKEN=1, SET_ACK=0, BUSY=0.
REQ-012 IDLE to ASSERT on a rising edge with SET_REQ=1 or PEND=1; CNT loads SET_W-1; PEND clears.
REQ-013 ASSERT: SETN=0, CLKEN=0, BUSY=1.
REQ-014 ASSERT holds SETN low exactly SET_W cycles, decrementing CNT; at CNT=0 it goes to RECOVER with CNT=REC_W-1, or to DONE when REC_W=0.
REQ-015 RECOVER: SETN=1, CLKEN=0, BUSY=1; lasts exactly REC_W cycles, then DONE.
REQ-016 DONE: lasts one cycle, SETN=1, CLKEN=1, BUSY=1, SET_ACK=1 only if the sequence was request-initiated (REQF=1); next state IDLE.
REQ-017 Latency: first cycle with SET_REQ=1 in IDLE -> SETN low on the following edge; SET_ACK high SET_W+REC_W cycles after that edge.
REQ-018 SET_REQ=1 sampled in ASSERT, RECOVER or DONE SHALL set the single-bit PEND flag; additional requests while PEND=1 SHALL merge.
REQ-019 SET_REQ held continuously high SHALL produce back-to-back sequences separated by exactly one IDLE cycle.
REQ-020 SETN and CLKEN SHALL never both be 0->1 in the same cycle except on the ASSERT->DONE transition when REC_W=0.
REQ-021 RN deassertion SHALL be synchronised through a 2-flop chain; the FSM leaves reset only after the chain outputs 1.

Reset
REQ-022 While RN=0: state=ASSERT, CNT=SET_W-1, SETN=0, CLKEN=0, SET_ACK=0, BUSY=1, PEND=0, REQF=0, immediately and without a CLK edge.
REQ-023 After synchronised release the block SHALL complete one full ASSERT+RECOVER+DONE sequence with REQF=0, i.e. no SET_ACK.
REQ-024 RN asserted mid-sequence SHALL abort it, discard PEND and any pending SET_ACK, and restart per REQ-022.

Verification
REQ-025 Defaults; RN low 3 cycles, release -> SETN=0 for 2 sync cycles + 4 cycles, CLKEN=0 2 further cycles, SET_ACK never 1, BUSY falls after DONE.
REQ-026 Idle; SET_REQ pulsed 1 cycle at cycle 10 -> SETN=0 cycles 11-14, RECOVER 15-16, SET_ACK=1 cycle 17 only, CLKEN=1 from cycle 17.
REQ-027 SET_REQ pulse during ASSERT of a running sequence -> PEND=1; after DONE, one IDLE cycle, then second sequence with its own SET_ACK.
REQ-028 SET_W=1, REC_W=0; SET_REQ held high -> SETN low 1 cycle, DONE, IDLE, repeating with period 3 cycles.
REQ-029 RN pulsed low during RECOVER (between CLK edges) -> SETN=0 and CLKEN=0 asynchronously, no SET_ACK, PEND cleared.
REQ-030 Checker on all tests: SETN low width >= SET_W cycles, no CLKEN=1 while SETN=0, SET_ACK width exactly 1 cycle.
